// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller sampled in the sys_clk domain: synchronises TCK/TMS/TDI and runs the 1149.1 state machine with IR, IDCODE and BYPASS.
// Optional trace output trace_code[3:0] is enabled by defining JTAG_TAP_TRACE_EN.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VAL   = 32'h0000_0001,
  parameter int          IDCODE_INSTR = 1,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                jtag_clk,
  input  logic                jtag_tms,
  input  logic                jtag_tdi,
  output logic                jtag_tdo,
  output logic [3:0]          tap_state,
  output logic                state_chg,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                ir_upd,
  output logic                dr_upd
`ifdef JTAG_TAP_TRACE_EN
  ,
  output logic [3:0]          trace_code
`endif
);

  typedef enum logic [3:0] {
    TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
    SHDR  = 4'd4,  EX1DR = 4'd5,  PDR   = 4'd6,  EX2DR = 4'd7,
    UPDR  = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
    EX1IR = 4'd12, PIR   = 4'd13, EX2IR = 4'd14, UPIR  = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] LP_IDCODE = IR_WIDTH'(IDCODE_INSTR);

  logic [SYNC_STAGES-1:0] r_tck_sync, r_tms_sync, r_tdi_sync, r_fill;
  logic                   r_tck_prev, r_armed;
  tap_state_e             r_state, w_state_next;
  logic [IR_WIDTH-1:0]    r_ir_sr, r_ir_out;
  logic [31:0]            r_id_sr;
  logic                   r_bypass, r_tdo, r_state_chg, r_ir_upd, r_dr_upd;
  logic                   w_tck, w_tms, w_tdi, w_rise, w_fall, w_sel_id;

  assign w_tck    = r_tck_sync[SYNC_STAGES-1];
  assign w_tms    = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi    = r_tdi_sync[SYNC_STAGES-1];
  // Edges count only once a genuine synchronised low has been seen since reset.
  assign w_rise   = r_armed & w_tck & ~r_tck_prev;
  assign w_fall   = r_armed & ~w_tck & r_tck_prev;
  assign w_sel_id = (r_ir_out == LP_IDCODE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_fill     <= '0;
      r_tck_prev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], jtag_clk};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], jtag_tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], jtag_tdi};
      r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_tck_prev <= w_tck;
      if (r_fill[SYNC_STAGES-1] && !w_tck) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= TLR;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rise) begin
      case (r_state)
        TLR:     w_state_next = w_tms ? TLR   : RTI;
        RTI:     w_state_next = w_tms ? SELDR : RTI;
        SELDR:   w_state_next = w_tms ? SELIR : CAPDR;
        CAPDR:   w_state_next = w_tms ? EX1DR : SHDR;
        SHDR:    w_state_next = w_tms ? EX1DR : SHDR;
        EX1DR:   w_state_next = w_tms ? UPDR  : PDR;
        PDR:     w_state_next = w_tms ? EX2DR : PDR;
        EX2DR:   w_state_next = w_tms ? UPDR  : SHDR;
        UPDR:    w_state_next = w_tms ? SELDR : RTI;
        SELIR:   w_state_next = w_tms ? TLR   : CAPIR;
        CAPIR:   w_state_next = w_tms ? EX1IR : SHIR;
        SHIR:    w_state_next = w_tms ? EX1IR : SHIR;
        EX1IR:   w_state_next = w_tms ? UPIR  : PIR;
        PIR:     w_state_next = w_tms ? EX2IR : PIR;
        EX2IR:   w_state_next = w_tms ? UPIR  : SHIR;
        UPIR:    w_state_next = w_tms ? SELDR : RTI;
        default: w_state_next = TLR;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ir_sr     <= '0;
      r_ir_out    <= LP_IDCODE;
      r_id_sr     <= '0;
      r_bypass    <= 1'b0;
      r_tdo       <= 1'b0;
      r_state_chg <= 1'b0;
      r_ir_upd    <= 1'b0;
      r_dr_upd    <= 1'b0;
    end else begin
      r_state_chg <= (w_state_next != r_state);
      r_ir_upd    <= (w_state_next == UPIR) && (r_state != UPIR);
      r_dr_upd    <= (w_state_next == UPDR) && (r_state != UPDR);
      if (w_rise) begin
        case (r_state)
          CAPIR: r_ir_sr <= IR_WIDTH'(2'b01);
          SHIR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_WIDTH-1:1]};
          CAPDR: if (w_sel_id) r_id_sr <= IDCODE_VAL;
                 else          r_bypass <= 1'b0;
          SHDR:  if (w_sel_id) r_id_sr <= {w_tdi, r_id_sr[31:1]};
                 else          r_bypass <= w_tdi;
          default: ;
        endcase
      end
      // The DR select changes only here, so a DR scan always sees a stable opcode.
      if (w_state_next == TLR)
        r_ir_out <= LP_IDCODE;
      else if ((w_state_next == UPIR) && (r_state != UPIR))
        r_ir_out <= r_ir_sr;
      if (w_fall) begin
        case (r_state)
          SHIR:    r_tdo <= r_ir_sr[0];
          SHDR:    r_tdo <= w_sel_id ? r_id_sr[0] : r_bypass;
          default: r_tdo <= 1'b0;
        endcase
      end
    end
  end

  assign jtag_tdo  = r_tdo;
  assign tap_state = r_state;
  assign state_chg = r_state_chg;
  assign ir_out    = r_ir_out;
  assign ir_upd    = r_ir_upd;
  assign dr_upd    = r_dr_upd;
`ifdef JTAG_TAP_TRACE_EN
  assign trace_code = r_state;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scans plus a random TMS/TDI walk against a table-driven TAP model.
module tb_jtag_tap_ctrl;
  localparam int          IR_W  = 4;
  localparam logic [31:0] IDVAL = 32'h1234_5679;
  localparam int          IDINS = 1;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, jtag_clk = 1'b0, jtag_tms = 1'b0, jtag_tdi = 1'b0;
  logic jtag_tdo, state_chg, ir_upd, dr_upd;
  logic [3:0] tap_state;
  logic [IR_W-1:0] ir_out;
`ifdef JTAG_TAP_TRACE_EN
  logic [3:0] trace_code;
`endif

  jtag_tap_ctrl #(.IR_WIDTH(IR_W), .IDCODE_VAL(IDVAL), .IDCODE_INSTR(IDINS), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .jtag_clk(jtag_clk), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo), .tap_state(tap_state), .state_chg(state_chg),
    .ir_out(ir_out), .ir_upd(ir_upd), .dr_upd(dr_upd)
`ifdef JTAG_TAP_TRACE_EN
    , .trace_code(trace_code)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0, n_err = 0;

  // TAP transition table indexed by state number, one array per TMS value.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_state, m_ir_sr, m_ir_out;
  logic [31:0] m_dr;
  bit          m_bp;

  // Observed and expected results of the most recent TCK cycle.
  logic o_tdo;
  int   o_chg, o_iu, o_du;
  bit   e_tdo;
  int   e_chg, e_iu, e_du;

  task automatic model_reset();
    m_state = 0; m_ir_sr = 0; m_ir_out = IDINS; m_dr = '0; m_bp = 1'b0;
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    int  old_s;
    bit  sel;
    sel   = (m_ir_out == IDINS);
    old_s = m_state;
    if (old_s == 11)     e_tdo = m_ir_sr[0];
    else if (old_s == 4) e_tdo = sel ? m_dr[0] : m_bp;
    else                 e_tdo = 1'b0;
    m_state = tms ? nxt1[old_s] : nxt0[old_s];
    case (old_s)
      10: m_ir_sr = 1;
      11: m_ir_sr = (m_ir_sr >> 1) | (int'(tdi) << (IR_W - 1));
      3:  if (sel) m_dr = IDVAL; else m_bp = 1'b0;
      4:  if (sel) m_dr = {tdi, m_dr[31:1]}; else m_bp = tdi;
      default: ;
    endcase
    e_chg = (m_state != old_s) ? 1 : 0;
    e_iu  = (m_state == 15 && old_s != 15) ? 1 : 0;
    e_du  = (m_state == 8 && old_s != 8) ? 1 : 0;
    if (e_iu == 1)     m_ir_out = m_ir_sr;
    if (m_state == 0)  m_ir_out = IDINS;
  endtask

  // One full TCK period (low then high), counting strobes and sampling TDO after the fall.
  task automatic step(input bit tms, input bit tdi);
    o_chg = 0; o_iu = 0; o_du = 0;
    model_step(tms, tdi);
    jtag_clk = 1'b0; jtag_tms = tms; jtag_tdi = tdi;
    repeat (6) begin
      @(negedge sys_clk);
      o_chg += int'(state_chg); o_iu += int'(ir_upd); o_du += int'(dr_upd);
    end
    o_tdo = jtag_tdo;
    jtag_clk = 1'b1;
    repeat (6) begin
      @(negedge sys_clk);
      o_chg += int'(state_chg); o_iu += int'(ir_upd); o_du += int'(dr_upd);
    end
    $display("tck tms=%0b tdi=%0b -> state=%0d tdo=%0b ir_out=%h chg=%0d iu=%0d du=%0d",
             tms, tdi, tap_state, o_tdo, ir_out, o_chg, o_iu, o_du);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; jtag_clk = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    n_vec++;
    if (tap_state !== 4'd0 || ir_out !== IR_W'(IDINS) || jtag_tdo !== 1'b0 ||
        state_chg !== 1'b0 || ir_upd !== 1'b0 || dr_upd !== 1'b0) begin
      n_err++;
      $display("FAIL reset: state=%0d ir=%h tdo=%b chg=%b iu=%b du=%b, required 0/%h/0/0/0/0",
               tap_state, ir_out, jtag_tdo, state_chg, ir_upd, dr_upd, IR_W'(IDINS));
    end
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_rti();
    step(0, 0);
    n_vec++;
    if (tap_state !== 4'd1 || o_chg != 1) begin
      n_err++; $display("FAIL rti_enter: state=%0d chg=%0d, required 1/1", tap_state, o_chg);
    end
    step(0, 0);
    n_vec++;
    if (tap_state !== 4'd1 || o_chg != 0) begin
      n_err++; $display("FAIL rti_loop: state=%0d chg=%0d, required 1/0", tap_state, o_chg);
    end
  endtask

  task automatic test_ir_shift();
    bit tdis [4] = '{0, 1, 1, 1};
    bit tdos [4] = '{1, 0, 0, 0};
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    n_vec++;
    if (tap_state !== 4'd11) begin
      n_err++; $display("FAIL ir_path: state=%0d, required 11", tap_state);
    end
    for (int i = 0; i < 4; i++) begin
      step((i == 3), tdis[i]);
      n_vec++;
      if (o_tdo !== tdos[i] || o_tdo !== e_tdo) begin
        n_err++; $display("FAIL ir_tdo[%0d]: got %b, required %b", i, o_tdo, tdos[i]);
      end
    end
    step(1, 0);
    n_vec++;
    if (ir_out !== 4'hE || o_iu != 1 || tap_state !== 4'd15) begin
      n_err++; $display("FAIL ir_update: ir=%h iu=%0d state=%0d, required e/1/15", ir_out, o_iu, tap_state);
    end
  endtask

  task automatic test_bypass();
    bit tdis [3] = '{1, 0, 1};
    bit tdos [3] = '{0, 1, 0};
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, tdis[i]);
      n_vec++;
      if (o_tdo !== tdos[i]) begin
        n_err++; $display("FAIL bypass_tdo[%0d]: got %b, required %b", i, o_tdo, tdos[i]);
      end
    end
    step(1, 0); step(1, 0);
    n_vec++;
    if (tap_state !== 4'd8 || o_du != 1) begin
      n_err++; $display("FAIL dr_update: state=%0d du=%0d, required 8/1", tap_state, o_du);
    end
  endtask

  task automatic test_tlr_from_shdr();
    int exp_s [5] = '{5, 8, 2, 9, 0};
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      n_vec++;
      if (tap_state !== 4'(exp_s[i])) begin
        n_err++; $display("FAIL tlr_walk[%0d]: state=%0d, required %0d", i, tap_state, exp_s[i]);
      end
    end
    n_vec++;
    if (ir_out !== IR_W'(IDINS)) begin
      n_err++; $display("FAIL tlr_ir: ir=%h, required %h", ir_out, IR_W'(IDINS));
    end
  endtask

  task automatic test_idcode();
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      step((i == 31), 1'($urandom_range(0, 1)));
      n_vec++;
      if (o_tdo !== IDVAL[i]) begin
        n_err++; $display("FAIL idcode_tdo[%0d]: got %b, required %b", i, o_tdo, IDVAL[i]);
      end
    end
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
  endtask

  task automatic test_reset_mid_shift();
    for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)));
    n_vec++;
    if (jtag_tdo !== e_tdo || jtag_tdo !== IDVAL[9]) begin
      n_err++; $display("FAIL pre_reset_tdo: got %b, required %b", jtag_tdo, IDVAL[9]);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_vec++;
    if (tap_state !== 4'd0 || jtag_tdo !== 1'b0 || ir_out !== IR_W'(IDINS)) begin
      n_err++; $display("FAIL mid_reset: state=%0d tdo=%b ir=%h, required 0/0/%h",
                        tap_state, jtag_tdo, ir_out, IR_W'(IDINS));
    end
    model_reset();
  endtask

  task automatic test_tck_high_release();
    int seen = 0;
    jtag_clk = 1'b1; jtag_tms = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (30) begin
      @(negedge sys_clk);
      seen += int'(state_chg);
    end
    n_vec++;
    if (tap_state !== 4'd0 || seen != 0) begin
      n_err++; $display("FAIL high_release: state=%0d chg=%0d, required 0/0", tap_state, seen);
    end
    step(0, 0);
    n_vec++;
    if (tap_state !== 4'd1 || o_chg != 1) begin
      n_err++; $display("FAIL first_edge: state=%0d chg=%0d, required 1/1", tap_state, o_chg);
    end
    // Scan the IR so later random DR scans start from captured contents.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_W; i++) step((i == IR_W - 1), 1'($urandom_range(0, 1)));
    step(1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)));
      n_vec++;
      if (tap_state !== 4'(m_state) || o_tdo !== e_tdo || ir_out !== IR_W'(m_ir_out) ||
          o_chg != e_chg || o_iu != e_iu || o_du != e_du) begin
        n_err++;
        $display("FAIL random[%0d]: state=%0d tdo=%b ir=%h chg=%0d iu=%0d du=%0d, required %0d/%b/%h/%0d/%0d/%0d",
                 i, tap_state, o_tdo, ir_out, o_chg, o_iu, o_du,
                 m_state, e_tdo, IR_W'(m_ir_out), e_chg, e_iu, e_du);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rti();
    test_ir_shift();
    test_bypass();
    test_tlr_from_shdr();
    test_idcode();
    test_reset_mid_shift();
    test_tck_high_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
